// File: rtl/adc_window_integrator_if.sv
// AXI-stream style packet output of the window integrator (64-bit beats).
interface adc_window_integrator_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_window_integrator.sv
// Sums each ADC channel over a programmable sample window and ships {header, timestamp, sums}
// as one packet; a shadow buffer decouples accumulation from the draining packet.
module adc_window_integrator #(
  parameter int          NUM_CH    = 16,
  parameter int          WIDTH     = 18,
  parameter int          SUM_WIDTH = 32,
  parameter logic [7:0]  HDR_ID    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [15:0]               window_len,
  input  logic                      in_valid,
  input  logic [63:0]               in_ts,
  input  logic [NUM_CH-1:0]         in_ch_valid,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  adc_window_integrator_if.master   m,
  output logic [31:0]               window_seq,
  output logic [15:0]               drop_count
);
  localparam int NPAIR = NUM_CH / 2;
  localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  typedef enum logic [1:0] {IDLE, HDR, TS, DATA} state_t;
  state_t state, state_nxt;

  logic signed [SUM_WIDTH-1:0] acc     [NUM_CH];
  logic signed [SUM_WIDTH-1:0] acc_sum [NUM_CH];
  logic [31:0]                 shadow  [NUM_CH];
  logic [63:0] sh_hdr, sh_ts, win_ts, cur_ts;
  logic [15:0] cnt, win_len, cur_len;
  logic [KW-1:0] pair_idx;
  logic take, complete, beat, last_beat, free, load;

  // The first sample of a window uses the live window_len/in_ts; later samples use the latched copies.
  always_comb begin
    take     = in_valid && ena;
    cur_len  = (cnt == 16'd0) ? ((window_len == 16'd0) ? 16'd1 : window_len) : win_len;
    cur_ts   = (cnt == 16'd0) ? in_ts : win_ts;
    complete = take && ((cnt + 16'd1) == cur_len);
    for (int n = 0; n < NUM_CH; n++)
      acc_sum[n] = acc[n] + (in_ch_valid[n] ? SUM_WIDTH'($signed(in_data[n*WIDTH +: WIDTH])) : '0);
  end

  assign beat      = m.tvalid && m.tready;
  assign last_beat = (state == DATA) && (pair_idx == KW'(NPAIR - 1));
  assign free      = (state == IDLE) || (beat && last_beat);
  assign load      = complete && free;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m.tvalid  = (state != IDLE);
    m.tlast   = last_beat;
    m.tdata   = '0;
    case (state)
      IDLE: if (load) state_nxt = HDR;
      HDR: begin
        m.tdata = sh_hdr;
        if (beat) state_nxt = TS;
      end
      TS: begin
        m.tdata = sh_ts;
        if (beat) state_nxt = DATA;
      end
      DATA: begin
        m.tdata = {shadow[{pair_idx, 1'b1}], shadow[{pair_idx, 1'b0}]};
        if (beat && last_beat) state_nxt = load ? HDR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      window_seq <= '0;
      drop_count <= '0;
      pair_idx   <= '0;
      for (int n = 0; n < NUM_CH; n++) acc[n] <= '0;
    end else begin
      if (beat && state == DATA)
        pair_idx <= last_beat ? '0 : pair_idx + KW'(1);
      if (!ena) begin
        cnt <= '0;
        for (int n = 0; n < NUM_CH; n++) acc[n] <= '0;
      end else if (take) begin
        if (cnt == 16'd0) begin
          win_ts  <= in_ts;
          win_len <= cur_len;
        end
        if (complete) begin
          cnt        <= '0;
          window_seq <= window_seq + 32'd1;
          for (int n = 0; n < NUM_CH; n++) acc[n] <= '0;
          if (load) begin
            for (int n = 0; n < NUM_CH; n++) shadow[n] <= 32'(acc_sum[n]);
            sh_hdr <= {HDR_ID, 8'(NUM_CH), cur_len, window_seq + 32'd1};
            sh_ts  <= cur_ts;
          end else if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
          end
        end else begin
          cnt <= cnt + 16'd1;
          for (int n = 0; n < NUM_CH; n++) acc[n] <= acc_sum[n];
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_window_integrator.sv
// Directed bench for adc_window_integrator with a packet-level reference model and per-cycle compare.
module tb_adc_window_integrator;
  localparam int NUM_CH = 16;
  localparam int WIDTH  = 18;

  logic clk = 1'b0;
  logic rst = 1'b1, ena = 1'b0, in_valid = 1'b0;
  logic [15:0] window_len = 16'd4;
  logic [63:0] in_ts = '0;
  logic [NUM_CH-1:0] in_ch_valid = '1;
  logic [NUM_CH*WIDTH-1:0] in_data = '0;
  logic [31:0] window_seq;
  logic [15:0] drop_count;

  adc_window_integrator_if axis ();

  adc_window_integrator dut (
    .clk(clk), .rst(rst), .ena(ena), .window_len(window_len), .in_valid(in_valid),
    .in_ts(in_ts), .in_ch_valid(in_ch_valid), .in_data(in_data), .m(axis),
    .window_seq(window_seq), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit started = 1'b0;
  logic [63:0] cap [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a window is a list of samples; a completed window becomes a list of words.
  logic signed [31:0] m_acc [NUM_CH];
  int          m_cnt, m_pos;
  logic [15:0] m_len, m_drop;
  logic [63:0] m_ts;
  logic [31:0] m_seq;
  bit          m_busy;
  logic [63:0] m_words [$];

  always @(posedge clk) begin : model
    bit hs, last_hs;
    if (rst) begin
      m_cnt = 0; m_seq = 0; m_drop = 0; m_busy = 0; m_pos = 0;
      foreach (m_acc[n]) m_acc[n] = '0;
    end else begin
      hs      = m_busy && axis.tready;
      last_hs = hs && (m_pos == m_words.size() - 1);
      if (hs) m_pos++;
      if (last_hs) m_busy = 0;
      if (!ena) begin
        m_cnt = 0;
        foreach (m_acc[n]) m_acc[n] = '0;
      end else if (in_valid) begin
        if (m_cnt == 0) begin
          m_ts  = in_ts;
          m_len = (window_len == 16'd0) ? 16'd1 : window_len;
        end
        for (int n = 0; n < NUM_CH; n++)
          if (in_ch_valid[n]) m_acc[n] = m_acc[n] + 32'($signed(in_data[n*WIDTH +: WIDTH]));
        m_cnt++;
        if (m_cnt == int'(m_len)) begin
          m_seq++;
          if (!m_busy) begin
            m_words.delete();
            m_words.push_back({8'hA5, 8'(NUM_CH), m_len, m_seq});
            m_words.push_back(m_ts);
            for (int k = 0; k < NUM_CH / 2; k++) m_words.push_back({m_acc[2*k+1], m_acc[2*k]});
            m_busy = 1;
            m_pos  = 0;
          end else if (m_drop != 16'hFFFF) begin
            m_drop++;
          end
          m_cnt = 0;
          foreach (m_acc[n]) m_acc[n] = '0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("tvalid", axis.tvalid, m_busy);
      chk("window_seq", window_seq, m_seq);
      chk("drop_count", drop_count, m_drop);
      if (m_busy) begin
        chk("tdata", axis.tdata, m_words[m_pos]);
        chk("tlast", axis.tlast, m_pos == m_words.size() - 1);
      end
    end
  end

  always @(posedge clk)
    if (started && !rst && axis.tvalid && axis.tready) cap.push_back(axis.tdata);

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; ena = 1'b0; in_ch_valid = '1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0; ena = 1'b1;
    cap.delete();
  endtask

  task automatic run_samples(int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_ts    = 64'd1000 + 64'(i);
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
  endtask

  task automatic set_all(int v);
    for (int n = 0; n < NUM_CH; n++) in_data[n*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic wait_cap(int n, int budget);
    int c = 0;
    while (cap.size() < n && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    checks++;
    if (cap.size() < n) begin
      errors++;
      $display("FAIL wait_cap: got %0d beats expected %0d", cap.size(), n);
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    do_reset();
    started = 1'b1;
    chk("rst_tvalid", axis.tvalid, 1'b0);
    chk("rst_tdata", axis.tdata, 64'd0);
    chk("rst_seq", window_seq, 32'd0);
    chk("rst_drop", drop_count, 16'd0);

    // Ramp data, 4-sample window
    window_len = 16'd4;
    for (int n = 0; n < NUM_CH; n++) in_data[n*WIDTH +: WIDTH] = WIDTH'(n + 1);
    run_samples(4);
    wait_cap(10, 50);
    chk("t1_hdr", cap[0], 64'hA510_0004_0000_0001);
    chk("t1_ts", cap[1], 64'd1000);
    chk("t1_w2", cap[2], {32'd8, 32'd4});
    chk("t1_w9", cap[9], {32'd64, 32'd60});

    // Most negative sample, sign extension
    do_reset();
    window_len = 16'd3;
    set_all(-131072);
    run_samples(3);
    wait_cap(10, 50);
    chk("t2_hdr", cap[0], 64'hA510_0003_0000_0001);
    chk("t2_sum", cap[5], 64'hFFFA0000_FFFA0000);

    // Channel 5 invalid on two of four samples
    do_reset();
    window_len = 16'd4;
    set_all(100);
    for (int i = 0; i < 4; i++) begin
      in_ch_valid = (i % 2 == 0) ? 16'hFFDF : 16'hFFFF;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    in_ch_valid = '1;
    wait_cap(10, 50);
    chk("t3_ch5", cap[4], {32'd200, 32'd400});
    chk("t3_ch67", cap[5], {32'd400, 32'd400});

    // Stalled sink, window_len 0 behaves as 1: one load then 29 drops
    do_reset();
    window_len = 16'd0;
    axis.tready = 1'b0;
    set_all(7);
    run_samples(30);
    chk("t4_drop", drop_count, 16'd29);
    chk("t4_seq", window_seq, 32'd30);
    chk("t4_held", axis.tdata, 64'hA510_0001_0000_0001);
    axis.tready = 1'b1;
    wait_cap(10, 50);
    chk("t4_sum", cap[2], {32'd7, 32'd7});

    // Window completion coincides with tlast handshake
    do_reset();
    window_len = 16'd10;
    set_all(1);
    run_samples(30);
    wait_cap(30, 80);
    chk("t5_drop", drop_count, 16'd0);
    chk("t5_seq", window_seq, 32'd3);
    chk("t5_hdr2", cap[10], 64'hA510_000A_0000_0002);
    chk("t5_hdr3", cap[20], 64'hA510_000A_0000_0003);
    chk("t5_sum", cap[12], {32'd10, 32'd10});

    // Reset on beat 4 truncates the packet
    do_reset();
    window_len = 16'd1;
    set_all(3);
    run_samples(1);
    wait_cap(3, 20);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_tvalid", axis.tvalid, 1'b0);
    chk("t6_seq", window_seq, 32'd0);
    chk("t6_drop", drop_count, 16'd0);
    rst = 1'b0;

    // ena low mid-window discards the partial sums
    cap.delete();
    window_len = 16'd4;
    set_all(50);
    run_samples(2);
    ena = 1'b0;
    @(posedge clk);
    #2;
    ena = 1'b1;
    set_all(2);
    run_samples(4);
    wait_cap(10, 50);
    chk("t6_hdr", cap[0], 64'hA510_0004_0000_0001);
    chk("t6_sum", cap[2], {32'd8, 32'd8});

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
